// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/ack data-memory access, store lane alignment, load extraction.
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses into two transactions.

module mem_stage_lsu #(
  parameter int DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               insn_vld_M,
  input  logic               mem_rd_en_M,
  input  logic               mem_wr_en_M,
  input  logic [3:0]         bmask_M,
  input  logic [2:0]         ld_sel_M,
  input  logic [31:0]        alu_data_M,
  input  logic [31:0]        rs2_data_M,
  input  logic               flush_M,
  input  logic               advance_M,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic [31:0]        ld_data_M,
  output logic               stall_M,
  output logic               misalign_M
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT0 = 2'd1, DONE = 2'd2, ACC1 = 2'd3} state_e;
`else
  localparam bit SPLIT_EN = 1'b0;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT0 = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e state_q, state_d;

  // Request decode straight from the M-stage inputs (used while IDLE)
  logic               access;
  logic [1:0]         off_in;
  logic [7:0]         m8;
  logic               cross_in;
  logic [DMEM_AW-1:0] base_in;
  logic [31:0]        w0_wdata_in;

  // Gating with rst_n drops the request the instant reset asserts, even mid-access.
  assign access      = rst_n & insn_vld_M & (mem_rd_en_M | mem_wr_en_M) & ~flush_M;
  assign off_in      = alu_data_M[1:0];
  assign m8          = {4'b0000, bmask_M} << off_in;
  assign cross_in    = |m8[7:4];
  assign base_in     = {alu_data_M[DMEM_AW-1:2], 2'b00};
  assign w0_wdata_in = rs2_data_M << {off_in, 3'b000};

  // Context captured at issue so an outstanding request stays stable even if the stage is flushed
  logic [DMEM_AW-1:0] base_q;
  logic               we_q;
  logic               ld_q;
  logic [1:0]         off_q;
  logic [2:0]         sel_q;
  logic [31:0]        w0_wdata_q;
  logic [3:0]         w0_be_q;
  logic [31:0]        done_q;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [31:0]        w1_wdata_in;
  logic               cross_q;
  logic [31:0]        w1_wdata_q;
  logic [3:0]         w1_be_q;
  logic [31:0]        lo_q;
  logic               cap_lo;
  logic               use_w1;

  assign w1_wdata_in = (off_in == 2'd0) ? 32'h0
                     : rs2_data_M >> (6'd32 - {1'b0, off_in, 3'b000});
`endif

  logic req;
  logic use_q;
  logic cap_ctx;
  logic complete;
  logic stall;
  logic misalign;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    use_q    = 1'b0;
    cap_ctx  = 1'b0;
    complete = 1'b0;
    stall    = 1'b0;
    misalign = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    cap_lo   = 1'b0;
    use_w1   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (access) begin
          cap_ctx = 1'b1;
          if (cross_in && !SPLIT_EN) begin
            misalign = 1'b1;
          end else begin
            req = 1'b1;
            if (!dmem_ack) begin
              state_d = WAIT0;
              stall   = 1'b1;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            else if (cross_in) begin
              state_d = ACC1;
              cap_lo  = 1'b1;
              stall   = 1'b1;
            end
`endif
            else begin
              complete = 1'b1;
            end
          end
        end
      end

      WAIT0: begin
        req   = 1'b1;
        use_q = 1'b1;
        stall = 1'b1;
        if (dmem_ack) begin
          if (flush_M) begin
            // In-flight word finished on the bus; any second split word is dropped.
            state_d = IDLE;
            stall   = 1'b0;
          end
`ifdef LSU_MISALIGN_SPLIT_EN
          else if (cross_q) begin
            state_d = ACC1;
            cap_lo  = 1'b1;
          end
`endif
          else begin
            complete = 1'b1;
          end
        end
      end

`ifdef LSU_MISALIGN_SPLIT_EN
      ACC1: begin
        req    = 1'b1;
        use_q  = 1'b1;
        use_w1 = 1'b1;
        stall  = 1'b1;
        if (dmem_ack) begin
          if (flush_M) begin
            state_d = IDLE;
            stall   = 1'b0;
          end else begin
            complete = 1'b1;
          end
        end
      end
`endif

      DONE: begin
        if (flush_M || advance_M) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (advance_M) begin
        state_d = IDLE;
        stall   = 1'b0;
      end else begin
        state_d = DONE;
        stall   = 1'b1;
      end
    end
  end

  // Field selection: live inputs while IDLE, captured context once the access is outstanding
  logic [DMEM_AW-1:0] cur_addr;
  logic [31:0]        cur_wdata;
  logic [3:0]         cur_be;
  logic               cur_we;
  logic               cur_ld;
  logic [2:0]         cur_sel;
  logic [1:0]         cur_off;

  always_comb begin
    cur_addr  = base_in;
    cur_wdata = w0_wdata_in;
    cur_be    = m8[3:0];
    cur_we    = mem_wr_en_M;
    cur_ld    = mem_rd_en_M;
    cur_sel   = ld_sel_M;
    cur_off   = off_in;
    if (use_q) begin
      cur_addr  = base_q;
      cur_wdata = w0_wdata_q;
      cur_be    = w0_be_q;
      cur_we    = we_q;
      cur_ld    = ld_q;
      cur_sel   = sel_q;
      cur_off   = off_q;
    end
`ifdef LSU_MISALIGN_SPLIT_EN
    if (use_w1) begin
      cur_addr  = base_q + DMEM_AW'(4);
      cur_wdata = w1_wdata_q;
      cur_be    = w1_be_q;
    end
`endif
  end

  // Load extraction: {word1, word0} shifted right by the byte offset
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  logic [31:0] ld_result;

`ifdef LSU_MISALIGN_SPLIT_EN
  always_comb begin
    if (use_w1) begin
      ld_word = (lo_q >> {cur_off, 3'b000})
              | (dmem_rdata << (6'd32 - {1'b0, cur_off, 3'b000}));
    end else begin
      ld_word = dmem_rdata >> {cur_off, 3'b000};
    end
  end
`else
  assign ld_word = dmem_rdata >> {cur_off, 3'b000};
`endif

  always_comb begin
    ld_ext = 32'h0;
    case (cur_sel)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b010:  ld_ext = ld_word;
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = 32'h0;
    endcase
  end

  assign ld_result = cur_ld ? ld_ext : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      we_q       <= 1'b0;
      ld_q       <= 1'b0;
      off_q      <= 2'd0;
      sel_q      <= 3'd0;
      w0_wdata_q <= 32'h0;
      w0_be_q    <= 4'h0;
      done_q     <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cross_q    <= 1'b0;
      w1_wdata_q <= 32'h0;
      w1_be_q    <= 4'h0;
      lo_q       <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      if (cap_ctx) begin
        base_q     <= base_in;
        we_q       <= mem_wr_en_M;
        ld_q       <= mem_rd_en_M;
        off_q      <= off_in;
        sel_q      <= ld_sel_M;
        w0_wdata_q <= w0_wdata_in;
        w0_be_q    <= m8[3:0];
`ifdef LSU_MISALIGN_SPLIT_EN
        cross_q    <= cross_in;
        w1_wdata_q <= w1_wdata_in;
        w1_be_q    <= m8[7:4];
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (cap_lo) lo_q <= dmem_rdata;
`endif
      if (complete && !advance_M) done_q <= ld_result;
    end
  end

  assign dmem_req   = req;
  assign dmem_we    = req & cur_we;
  assign dmem_addr  = req ? cur_addr : '0;
  assign dmem_wdata = req ? cur_wdata : 32'h0;
  assign dmem_be    = req ? cur_be : 4'h0;
  assign ld_data_M  = (state_q == DONE) ? done_q : (complete ? ld_result : 32'h0);
  assign stall_M    = stall;
  assign misalign_M = misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu; hand-computed expectations per vector.
// Crossing-access checks follow the LSU_MISALIGN_SPLIT_EN build option.

module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        insn_vld_M;
  logic        mem_rd_en_M;
  logic        mem_wr_en_M;
  logic [3:0]  bmask_M;
  logic [2:0]  ld_sel_M;
  logic [31:0] alu_data_M;
  logic [31:0] rs2_data_M;
  logic        flush_M;
  logic        advance_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] ld_data_M;
  logic        stall_M;
  logic        misalign_M;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_lsu #(.DMEM_AW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .insn_vld_M  (insn_vld_M),
    .mem_rd_en_M (mem_rd_en_M),
    .mem_wr_en_M (mem_wr_en_M),
    .bmask_M     (bmask_M),
    .ld_sel_M    (ld_sel_M),
    .alu_data_M  (alu_data_M),
    .rs2_data_M  (rs2_data_M),
    .flush_M     (flush_M),
    .advance_M   (advance_M),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .ld_data_M   (ld_data_M),
    .stall_M     (stall_M),
    .misalign_M  (misalign_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    insn_vld_M  = 1'b0;
    mem_rd_en_M = 1'b0;
    mem_wr_en_M = 1'b0;
    bmask_M     = 4'h0;
    ld_sel_M    = 3'd0;
    alu_data_M  = 32'h0;
    rs2_data_M  = 32'h0;
    flush_M     = 1'b0;
    advance_M   = 1'b1;
    dmem_ack    = 1'b0;
    dmem_rdata  = 32'h0;
  endtask

  task automatic drive_acc(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] bm, input logic [2:0] sel, input logic [31:0] data);
    insn_vld_M  = 1'b1;
    mem_rd_en_M = rd;
    mem_wr_en_M = wr;
    alu_data_M  = addr;
    bmask_M     = bm;
    ld_sel_M    = sel;
    rs2_data_M  = data;
  endtask

  // Zero-wait load: result must appear combinationally with no stall, then the unit is idle again.
  task automatic load_1c(input string tag, input logic [31:0] addr, input logic [3:0] bm,
                         input logic [2:0] sel, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic [3:0] exp_be);
    @(negedge clk);
    drive_acc(1'b1, 1'b0, addr, bm, sel, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    #1;
    check({tag, " data"}, ld_data_M, exp_data);
    check({tag, " stall"}, 32'(stall_M), 32'h0);
    check({tag, " be"}, 32'(dmem_be), 32'(exp_be));
    check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    drive_idle();
    #1;
    check({tag, " idle after"}, {30'h0, dmem_req, stall_M}, 32'h0);
  endtask

  int stall_cnt;

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check("reset req", 32'(dmem_req), 32'h0);
    check("reset stall/misalign", {30'h0, stall_M, misalign_M}, 32'h0);
    check("reset outputs", {dmem_addr[27:0], dmem_be} | dmem_wdata | ld_data_M, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic loads with immediate ack
    load_1c("LW 0x100",  32'h100, 4'b1111, 3'b010, 32'h8899AABB, 32'h8899AABB, 4'b1111);
    load_1c("LB 0x103",  32'h103, 4'b0001, 3'b000, 32'h80112233, 32'hFFFFFF80, 4'b1000);
    load_1c("LBU 0x103", 32'h103, 4'b0001, 3'b100, 32'h80112233, 32'h00000080, 4'b1000);
    load_1c("LHU 0x101", 32'h101, 4'b0011, 3'b101, 32'h12345678, 32'h00003456, 4'b0110);
    load_1c("LH 0x102",  32'h102, 4'b0011, 3'b001, 32'hF00D1234, 32'hFFFFF00D, 4'b1100);
    load_1c("bad sel",   32'h100, 4'b1111, 3'b011, 32'h12345678, 32'h00000000, 4'b1111);

    // Half at off=1 never flags misalign in either build
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h101, 4'b0011, 3'b101, 32'h0);
    dmem_ack = 1'b1;
    #1;
    check("LHU off1 misalign", 32'(misalign_M), 32'h0);
    @(negedge clk);
    drive_idle();

    // SB with ack after 3 wait cycles: request stable 4 cycles, stall 3 cycles
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_acc(1'b0, 1'b1, 32'h102, 4'b0001, 3'b000, 32'h000000AB);
      dmem_ack = (i == 3);
      #1;
      check($sformatf("SB req c%0d", i), {29'h0, dmem_req, dmem_we, 1'b0}, 32'h6);
      check($sformatf("SB be c%0d", i), 32'(dmem_be), 32'h4);
      check($sformatf("SB wdata c%0d", i), dmem_wdata, 32'h00AB0000);
      check($sformatf("SB addr c%0d", i), dmem_addr, 32'h100);
      if (stall_M) stall_cnt++;
    end
    check("SB ld_data", ld_data_M, 32'h0);
    check("SB stall cycles", 32'(stall_cnt), 32'd3);
    @(negedge clk);
    drive_idle();
    #1;
    check("SB idle after", {30'h0, dmem_req, stall_M}, 32'h0);

    // Ack while no request is ignored; a following load takes the wait path from IDLE
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("stray ack", {dmem_req, stall_M, ld_data_M[29:0]}, 32'h0);
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h202, 4'b0011, 3'b001, 32'h0);
    dmem_ack = 1'b0;
    #1;
    check("LH wait c0 stall", 32'(stall_M), 32'h1);
    @(negedge clk);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80015555;
    #1;
    check("LH wait c1 data", ld_data_M, 32'hFFFF8001);
    check("LH wait c1 stall", 32'(stall_M), 32'h0);
    check("LH wait c1 addr", dmem_addr, 32'h200);
    @(negedge clk);
    drive_idle();

    // Completion without advance: DONE holds the data until advance_M
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h200, 4'b1111, 3'b010, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    advance_M  = 1'b0;
    #1;
    check("DONE c0 data", ld_data_M, 32'hCAFEF00D);
    check("DONE c0 stall", 32'(stall_M), 32'h1);
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0BADBEEF;
    #1;
    check("DONE c1 data", ld_data_M, 32'hCAFEF00D);
    check("DONE c1 stall/req", {30'h0, stall_M, dmem_req}, 32'h2);
    @(negedge clk);
    advance_M = 1'b1;
    #1;
    check("DONE c2 data", ld_data_M, 32'hCAFEF00D);
    check("DONE c2 stall", 32'(stall_M), 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check("DONE idle after", {dmem_req, stall_M, ld_data_M[29:0]}, 32'h0);

    // Flush while waiting: request held to ack, then IDLE (not DONE, despite advance_M=0)
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h300, 4'b1111, 3'b010, 32'h0);
    advance_M = 1'b0;
    #1;
    check("FLUSH c0 req/stall", {30'h0, dmem_req, stall_M}, 32'h3);
    @(negedge clk);
    flush_M = 1'b1;
    #1;
    check("FLUSH c1 req/stall", {30'h0, dmem_req, stall_M}, 32'h3);
    check("FLUSH c1 addr", dmem_addr, 32'h300);
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    check("FLUSH ack req/stall", {30'h0, dmem_req, stall_M}, 32'h2);
    @(negedge clk);
    drive_idle();
    advance_M = 1'b0;
    #1;
    check("FLUSH idle after", {30'h0, dmem_req, stall_M}, 32'h0);

    // Async reset in WAIT0 drops the request immediately
    @(negedge clk);
    drive_acc(1'b0, 1'b1, 32'h400, 4'b1111, 3'b000, 32'h12345678);
    advance_M = 1'b1;
    @(negedge clk);
    #1;
    check("RST pre req/stall", {30'h0, dmem_req, stall_M}, 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("RST mid req/stall", {30'h0, dmem_req, stall_M}, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    check("RST after req/stall", {30'h0, dmem_req, stall_M}, 32'h0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Split LW 0x102: word 0 at 0x100, word 1 at 0x104
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h102, 4'b1111, 3'b010, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11223344;
    #1;
    check("SPLIT LW w0 addr", dmem_addr, 32'h100);
    check("SPLIT LW w0 be", 32'(dmem_be), 32'hC);
    check("SPLIT LW w0 stall/misalign", {30'h0, stall_M, misalign_M}, 32'h2);
    @(negedge clk);
    dmem_rdata = 32'h55667788;
    #1;
    check("SPLIT LW w1 addr", dmem_addr, 32'h104);
    check("SPLIT LW w1 be", 32'(dmem_be), 32'h3);
    check("SPLIT LW data", ld_data_M, 32'h77881122);
    check("SPLIT LW w1 stall", 32'(stall_M), 32'h0);
    @(negedge clk);
    drive_idle();

    // Split SW 0x103: lanes wrap into the second word
    @(negedge clk);
    drive_acc(1'b0, 1'b1, 32'h103, 4'b1111, 3'b000, 32'hAABBCCDD);
    dmem_ack = 1'b1;
    #1;
    check("SPLIT SW w0 wdata", dmem_wdata, 32'hDD000000);
    check("SPLIT SW w0 be", 32'(dmem_be), 32'h8);
    @(negedge clk);
    #1;
    check("SPLIT SW w1 wdata", dmem_wdata, 32'h00AABBCC);
    check("SPLIT SW w1 be/addr", {dmem_addr[27:0], dmem_be}, {28'h0000104, 4'h7});
    @(negedge clk);
    drive_idle();
    #1;
    check("SPLIT idle after", {30'h0, dmem_req, stall_M}, 32'h0);
`else
    // Crossing accesses are flagged and never reach the bus
    @(negedge clk);
    drive_acc(1'b1, 1'b0, 32'h102, 4'b1111, 3'b010, 32'h0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11223344;
    #1;
    check("MIS LW misalign", 32'(misalign_M), 32'h1);
    check("MIS LW req/stall", {30'h0, dmem_req, stall_M}, 32'h0);
    check("MIS LW data", ld_data_M, 32'h0);
    @(negedge clk);
    drive_acc(1'b0, 1'b1, 32'h103, 4'b0011, 3'b000, 32'hBEEF);
    #1;
    check("MIS SH misalign", 32'(misalign_M), 32'h1);
    check("MIS SH req/stall", {30'h0, dmem_req, stall_M}, 32'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check("MIS idle after", {29'h0, dmem_req, stall_M, misalign_M}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
